// File: rtl/matrix_stream_pkg.sv
// Shared types and defaults for the matrix operand streamer.
package matrix_stream_pkg;

    localparam int OP_W     = 6;
    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int DEF_DW   = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM_A = 2'd1,
        STREAM_B = 2'd2,
        DONE     = 2'd3
    } stream_state_t;

endpackage

// File: rtl/stream_index_gen.sv
// Row/column element counter producing a linear row-major address and a
// last-element flag; transpose makes the row the fast-moving coordinate.
module stream_index_gen #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int AW   = $clog2(ROWS*COLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    input  logic          transpose,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic          row_end;
    logic          col_end;

    assign row_end = (row_reg == RW'(ROWS - 1));
    assign col_end = (col_reg == CW'(COLS - 1));
    assign last    = row_end && col_end;
    assign addr    = AW'(32'(row_reg) * COLS + 32'(col_reg));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (clear || (advance && last)) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (advance) begin
            if (transpose) begin
                if (row_end) begin
                    row_reg <= '0;
                    col_reg <= col_reg + CW'(1);
                end else begin
                    row_reg <= row_reg + RW'(1);
                end
            end else begin
                if (col_end) begin
                    col_reg <= '0;
                    row_reg <= row_reg + RW'(1);
                end else begin
                    col_reg <= col_reg + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matrix_operand_streamer.sv
// Streams operand matrices A then B (or A only) to the matrix ALU with a valid/ready
// handshake. Define STREAMER_TRANSPOSE_EN to stream B column-major.
module matrix_operand_streamer
    import matrix_stream_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW,
    parameter int AW   = $clog2(ROWS*COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_err,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic            unary,
    output logic [OP_W-1:0] sel,
    output logic [DW-1:0]   ele_data,
    output logic            ele_valid,
    input  logic            ele_ready,
    output logic            ele_last,
    output logic            busy,
    output logic            done
);

    localparam int N = ROWS * COLS;

    stream_state_t   state_reg, state_next;
    logic [OP_W-1:0] sel_reg;
    logic            unary_reg;
    logic            wr_err_reg;

    logic [DW-1:0]   a_mem [N];
    logic [DW-1:0]   b_mem [N];
    logic [N-1:0]    a_we;
    logic [N-1:0]    b_we;
    logic            wr_ok;

    logic            accept;
    logic            idx_clear;
    logic            idx_last;
    logic            transpose;
    logic [AW-1:0]   idx_addr;

    // Writes only land while idle so a running stream never sees a torn matrix.
    assign wr_ok = wr_en && (state_reg == IDLE);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_we
            assign a_we[gi] = wr_ok && !wr_sel && (wr_addr == AW'(gi));
            assign b_we[gi] = wr_ok &&  wr_sel && (wr_addr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (a_we[i]) a_mem[i] <= wr_data;
            if (b_we[i]) b_mem[i] <= wr_data;
        end
    end

    assign ele_valid = (state_reg == STREAM_A) || (state_reg == STREAM_B);
    assign accept    = ele_valid && ele_ready;
    assign idx_clear = !ele_valid;

`ifdef STREAMER_TRANSPOSE_EN
    assign transpose = (state_reg == STREAM_B);
`else
    assign transpose = 1'b0;
`endif

    stream_index_gen #(
        .ROWS (ROWS),
        .COLS (COLS),
        .AW   (AW)
    ) u_index (
        .clk       (clk),
        .reset     (reset),
        .clear     (idx_clear),
        .advance   (accept),
        .transpose (transpose),
        .addr      (idx_addr),
        .last      (idx_last)
    );

    assign ele_data = (state_reg == STREAM_B) ? b_mem[idx_addr] : a_mem[idx_addr];
    assign ele_last = idx_last && ((state_reg == STREAM_B) ||
                                   ((state_reg == STREAM_A) && unary_reg));
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign sel      = sel_reg;
    assign wr_err   = wr_err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            unary_reg  <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_err_reg <= wr_en && (state_reg != IDLE);
            if ((state_reg == IDLE) && start) begin
                sel_reg   <= op;
                unary_reg <= unary;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = STREAM_A;
            STREAM_A: if (accept && idx_last) state_next = unary_reg ? DONE : STREAM_B;
            STREAM_B: if (accept && idx_last) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

endmodule
